// File: rtl/rns_to_bin_mrc.sv
// Reverse converter from the {13, 11, 7, 5} residue system to binary.
// It uses sequential mixed-radix conversion and produces one digit per cycle.
// X = a1 + 13*a2 + 143*a3 + 1001*a4, where each a_i is a mixed-radix digit.
module rns_to_bin_mrc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  R13,
  input  logic [3:0]  R11,
  input  logic [2:0]  R7,
  input  logic [2:0]  R5,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] X,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, A2, A3, A4, SUM, OUT} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [3:0]  r_a1;
  logic [3:0]  r_a2;
  logic [2:0]  r_a3;
  logic [2:0]  r_a4;
  logic [3:0]  r_r11;
  logic [2:0]  r_r7;
  logic [2:0]  r_r5;
  logic        r_errIn;
  logic        r_outValid;
  logic [12:0] r_x;
  logic        r_err;

  logic [3:0]  w_a1Mod11, w_d2, w_a2Next;
  logic [3:0]  w_a1Mod7, w_a2Mod7, w_d3a, w_m3a, w_d3b;
  logic [2:0]  w_a3Next;
  logic [3:0]  w_a1Mod5, w_a2Mod5, w_a3Mod5, w_d4a, w_m4a, w_d4b, w_d4c;
  logic [2:0]  w_a4Next;
  logic [12:0] w_sum;

  // Subtract in 5-bit two's complement and fold a negative result back by adding the modulus.
  function automatic logic [3:0] subMod(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] m);
    logic [4:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[4]) d = d + {1'b0, m};
    return d[3:0];
  endfunction

  // Reduce a digit in 0..12 modulo 5 using two compare/subtract steps.
  function automatic logic [3:0] mod5(input logic [3:0] v);
    if (v >= 4'd10)     return v - 4'd10;
    else if (v >= 4'd5) return v - 4'd5;
    else                return v;
  endfunction

  // Digit arithmetic for each MRC step. Products are at most 90, so a constant modulo keeps them small.
  always_comb begin
    w_a1Mod11 = (r_a1 >= 4'd11) ? r_a1 - 4'd11 : r_a1;
    w_d2      = subMod(r_r11, w_a1Mod11, 4'd11);
    w_a2Next  = 4'(({4'd0, w_d2} * 8'd6) % 8'd11);

    w_a1Mod7  = (r_a1 >= 4'd7) ? r_a1 - 4'd7 : r_a1;
    w_a2Mod7  = (r_a2 >= 4'd7) ? r_a2 - 4'd7 : r_a2;
    w_d3a     = subMod({1'b0, r_r7}, w_a1Mod7, 4'd7);
    w_m3a     = 4'(({4'd0, w_d3a} * 8'd6) % 8'd7);
    w_d3b     = subMod(w_m3a, w_a2Mod7, 4'd7);
    w_a3Next  = 3'(({4'd0, w_d3b} * 8'd2) % 8'd7);

    w_a1Mod5  = mod5(r_a1);
    w_a2Mod5  = mod5(r_a2);
    w_a3Mod5  = mod5({1'b0, r_a3});
    w_d4a     = subMod({1'b0, r_r5}, w_a1Mod5, 4'd5);
    w_m4a     = 4'(({4'd0, w_d4a} * 8'd2) % 8'd5);
    w_d4b     = subMod(w_m4a, w_a2Mod5, 4'd5);
    w_d4c     = subMod(w_d4b, w_a3Mod5, 4'd5);
    w_a4Next  = 3'(({4'd0, w_d4c} * 8'd3) % 8'd5);

    w_sum     = {9'd0, r_a1} + 13'd13 * {9'd0, r_a2}
              + 13'd143 * {10'd0, r_a3} + 13'd1001 * {10'd0, r_a4};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. The converter steps through the digits and then waits in OUT for the consumer.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_nextState = A2;
      A2:      w_nextState = A3;
      A3:      w_nextState = A4;
      A4:      w_nextState = SUM;
      SUM:     w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers. Residues are captured at accept, digits are filled in one per cycle, and the result is held until it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1       <= '0;
      r_a2       <= '0;
      r_a3       <= '0;
      r_a4       <= '0;
      r_r11      <= '0;
      r_r7       <= '0;
      r_r5       <= '0;
      r_errIn    <= 1'b0;
      r_outValid <= 1'b0;
      r_x        <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a1    <= R13;
          r_r11   <= R11;
          r_r7    <= R7;
          r_r5    <= R5;
          r_errIn <= (R13 > 4'd12) | (R11 > 4'd10) | (R7 > 3'd6) | (R5 > 3'd4);
        end
        A2:  r_a2 <= w_a2Next;
        A3:  r_a3 <= w_a3Next;
        A4:  r_a4 <= w_a4Next;
        SUM: begin
          r_x        <= r_errIn ? 13'd0 : w_sum;
          r_err      <= r_errIn;
          r_outValid <= 1'b1;
        end
        OUT: if (out_ready) r_outValid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign X         = r_x;
  assign err       = r_err;

endmodule

// File: tb/tb_rns_to_bin_mrc.sv
// Self-checking bench for rns_to_bin_mrc. Expected results come from a brute-force
// Chinese-remainder search over 0..5004.
module tb_rns_to_bin_mrc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  R13;
  logic [3:0]  R11;
  logic [2:0]  R7;
  logic [2:0]  R5;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] X;
  logic        err;

  int     checkCount = 0;
  int     errorCount = 0;
  longint lastAccept = 0;
  bit     spacingOn  = 1'b0;

  // Generate a free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  rns_to_bin_mrc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R13       (R13),
    .R11       (R11),
    .R7        (R7),
    .R5        (R5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .err       (err)
  );

  // Count one comparison and report it if the observed value differs from the expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference result {err, X}. The expected X is the unique value in 0..5004 that has these four residues.
  function automatic logic [13:0] refModel(input int r13, input int r11, input int r7, input int r5);
    if (r13 > 12 || r11 > 10 || r7 > 6 || r5 > 4) return {1'b1, 13'd0};
    for (int x = 0; x < 5005; x++)
      if (x % 13 == r13 && x % 11 == r11 && x % 7 == r7 && x % 5 == r5)
        return {1'b0, 13'(x)};
    return {1'b1, 13'h1fff};
  endfunction

  // Present one vector and check latency, the result, the hold behaviour under backpressure, and the return to idle.
  task automatic applyStimulus(input logic [3:0] a13, input logic [3:0] a11,
                               input logic [2:0] a7, input logic [2:0] a5,
                               input int holdCycles);
    logic [13:0] expected;
    int n;
    expected  = refModel(int'(a13), int'(a11), int'(a7), int'(a5));
    out_ready = (holdCycles == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("inReadyBeforeAccept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    R13 = a13; R11 = a11; R7 = a7; R5 = a5;
    @(posedge clk);
    if (spacingOn) checkOutput("acceptSpacing", 32'($time - lastAccept), 32'd60);
    lastAccept = $time;
    #1;
    in_valid = 1'b0;
    R13 = 4'($urandom); R11 = 4'($urandom); R7 = 3'($urandom); R5 = 3'($urandom);
    checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("latency", n, 32'd4);
    checkOutput("X", 32'(X), 32'(expected[12:0]));
    checkOutput("err", 32'(err), 32'(expected[13]));
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = i[0];
      R13 = 4'($urandom); R11 = 4'($urandom); R7 = 3'($urandom); R5 = 3'($urandom);
      @(posedge clk); #1;
      checkOutput("holdX", 32'(X), 32'(expected[12:0]));
      checkOutput("holdErr", 32'(err), 32'(expected[13]));
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("validDropped", 32'(out_valid), 32'd0);
    checkOutput("inReadyAfter", 32'(in_ready), 32'd1);
    checkOutput("xHeld", 32'(X), 32'(expected[12:0]));
  endtask

  // Main sequence: reset values, directed cases, reset during a conversion, backpressure, and back-to-back random traffic.
  initial begin
    logic [3:0] v13, v11;
    logic [2:0] v7, v5;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    R13 = '0; R11 = '0; R7 = '0; R5 = '0;
    #12;
    checkOutput("resetX", 32'(X), 32'd0);
    checkOutput("resetErr", 32'(err), 32'd0);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(4'd12, 4'd10, 3'd6, 3'd0, 0);

    // Reset asserted mid-cycle while the converter is in A3.
    in_valid = 1'b1;
    R13 = 4'd12; R11 = 4'd10; R7 = 3'd6; R5 = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midResetX", 32'(X), 32'd0);
    checkOutput("midResetErr", 32'(err), 32'd0);
    checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
    checkOutput("midResetInReady", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("noResultAfterReset", seen, 32'd0);

    applyStimulus(4'd0, 4'd0, 3'd0, 3'd0, 0);
    applyStimulus(4'd12, 4'd10, 3'd6, 3'd4, 0);
    applyStimulus(4'd1, 4'd1, 3'd1, 3'd1, 0);
    applyStimulus(4'd12, 4'd1, 3'd3, 3'd0, 0);
    applyStimulus(4'd13, 4'd0, 3'd0, 3'd0, 0);
    applyStimulus(4'd0, 4'd11, 3'd0, 3'd0, 0);
    applyStimulus(4'd12, 4'd10, 3'd6, 3'd0, 0);
    applyStimulus(4'd1, 4'd1, 3'd1, 3'd1, 10);
    applyStimulus(4'd15, 4'd2, 3'd7, 3'd3, 10);

    applyStimulus(4'd3, 4'd4, 3'd5, 3'd2, 0);
    spacingOn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        v13 = 4'($urandom); v11 = 4'($urandom); v7 = 3'($urandom); v5 = 3'($urandom);
      end else begin
        v13 = 4'($urandom_range(0, 12)); v11 = 4'($urandom_range(0, 10));
        v7  = 3'($urandom_range(0, 6));  v5  = 3'($urandom_range(0, 4));
      end
      applyStimulus(v13, v11, v7, v5, 0);
    end
    spacingOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
